// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared definitions for the ALU command sequencer: default
//             datapath width, arithmetic unit select encodings and the
//             sequencer FSM state type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  // Default operand/result width; must match the external arithmetic unit.
  localparam int W_DEFAULT = 16;

  // Iteration counter width used when the repeat feature is built.
  localparam int RPT_W = 4;

  // Arithmetic unit select codes.
  typedef enum logic [2:0] {
    OP_ONE  = 3'd0,
    OP_DEC  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_MUL  = 3'd4,
    OP_MULN = 3'd5,
    OP_DBL  = 3'd6,
    OP_INC  = 3'd7
  } alu_op_t;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Command front-end for the shared combinational arithmetic
//             unit. Accepts a command over a valid/ready handshake, drives
//             the unit from registers, captures its result into an
//             accumulator plus carry/zero/equal flags, and returns them over
//             a response handshake.
//  Config   : ALU_SEQ_REPEAT_EN - when defined, cmd_rpt extra iterations
//             are executed, each feeding the previous result back as in_a.
//             When undefined cmd_rpt is ignored and every command runs
//             exactly one EXEC cycle.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             cmd_valid/cmd_ready   - command handshake
//             cmd_op, cmd_a, cmd_b  - select code and operands
//             cmd_use_acc           - take in_a from the accumulator
//             cmd_use_carry         - feed the carry flag into carry_in
//             cmd_rpt               - extra iterations (repeat build only)
//             alu_select, alu_in_a, alu_in_b, alu_carry_in - unit drive
//             alu_out, alu_carry_out, alu_compare          - unit results
//             rsp_valid/rsp_ready   - response handshake
//             rsp_data, rsp_carry, rsp_zero, rsp_eq        - response
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_use_carry,
  input  logic [RPT_W-1:0] cmd_rpt,
  // arithmetic unit drive
  output logic [2:0]       alu_select,
  output logic [W-1:0]     alu_in_a,
  output logic [W-1:0]     alu_in_b,
  output logic             alu_carry_in,
  // arithmetic unit results
  input  logic [W-1:0]     alu_out,
  input  logic             alu_carry_out,
  input  logic             alu_compare,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_eq
);

  seq_state_t   r_state;
  logic [W-1:0] r_acc;
  logic         r_carry;
  logic         r_zero;
  logic         r_eq;
  // Remembers cmd_use_carry for carry feedback between repeat iterations.
  logic         r_use_carry;
  logic         w_last_iter;

`ifdef ALU_SEQ_REPEAT_EN
  logic [RPT_W-1:0] r_iter;
  assign w_last_iter = (r_iter == '0);
`else
  // Repeat count is accepted on the port but has no effect in this build.
  logic unused_rpt;
  assign unused_rpt  = ^cmd_rpt;
  assign w_last_iter = 1'b1;
`endif

  // The response fields are the accumulator and flag registers themselves;
  // they only change in EXEC, so they are naturally stable during RESP.
  assign rsp_data  = r_acc;
  assign rsp_carry = r_carry;
  assign rsp_zero  = r_zero;
  assign rsp_eq    = r_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      r_acc        <= '0;
      r_carry      <= 1'b0;
      r_zero       <= 1'b0;
      r_eq         <= 1'b0;
      r_use_carry  <= 1'b0;
      alu_select   <= 3'd0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_carry_in <= 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
      r_iter       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_select   <= cmd_op;
            alu_in_a     <= cmd_use_acc ? r_acc : cmd_a;
            alu_in_b     <= cmd_b;
            alu_carry_in <= cmd_use_carry & r_carry;
            r_use_carry  <= cmd_use_carry;
`ifdef ALU_SEQ_REPEAT_EN
            r_iter       <= cmd_rpt;
`endif
            cmd_ready    <= 1'b0;
            r_state      <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // The unit has settled on the registered drive during this cycle.
          r_acc   <= alu_out;
          r_carry <= alu_carry_out;
          r_eq    <= alu_compare;
          r_zero  <= (alu_out == '0);
          if (w_last_iter) begin
            rsp_valid <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
`ifdef ALU_SEQ_REPEAT_EN
            r_iter <= r_iter - 1'b1;
`endif
            alu_in_a     <= alu_out;
            alu_carry_in <= r_use_carry & alu_carry_out;
          end
        end

        ST_RESP: begin
          // cmd_ready only returns after the response handshake, so the
          // two channels can never complete in the same cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : alu_sequencer
`default_nettype wire
